// File: rtl/timer_ctrl_pkg.sv
// Shared constants for the BCD countdown timer: state codes, digit limits and time constants.
package timer_ctrl_pkg;

    localparam int              DIGIT_W     = 4;
    localparam logic [3:0]      DIGIT_MAX_9 = 4'd9;
    localparam logic [3:0]      DIGIT_MAX_5 = 4'd5;
    localparam logic [15:0]     TIME_ZERO   = 16'h0000;
    localparam logic [15:0]     TIME_ONE    = 16'h0001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // A preset is usable only if all four digits are BCD and tens-of-seconds stays below 6.
    function automatic logic preset_valid(input logic [15:0] p);
        return (p[15:12] <= DIGIT_MAX_9) && (p[11:8] <= DIGIT_MAX_9) &&
               (p[7:4]   <= DIGIT_MAX_5) && (p[3:0]  <= DIGIT_MAX_9);
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit that wraps 0 -> MAX; borrow_out flags a zero digit for the chain.
module bcd_down_digit
    import timer_ctrl_pkg::*;
#(
    parameter logic [DIGIT_W-1:0] MAX = DIGIT_MAX_9
) (
    input  logic               clk_1Hz,
    input  logic               clr_n,
    input  logic               dec_en,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_val,
    output logic [DIGIT_W-1:0] digit,
    output logic               borrow_out
);

    always_ff @(posedge clk_1Hz or negedge clr_n) begin
        if (!clr_n) begin
            digit <= '0;
        end else if (load) begin
            digit <= load_val;
        end else if (dec_en) begin
            digit <= (digit == '0) ? MAX : digit - 4'd1;
        end
    end

    // Registered-only zero flag; the parent ANDs it with the enable to form the ripple borrow.
    assign borrow_out = (digit == '0);

endmodule

// File: rtl/timer_ctrl.sv
// mm:ss BCD countdown timer FSM with load/start/stop control and chained digit counters.
// Optional build macro TIMER_CTRL_AUTO_RELOAD_EN reloads the preset on expiry instead of stopping.
module timer_ctrl
    import timer_ctrl_pkg::*;
(
    input  logic        clk_1Hz,
    input  logic        clr_n,
    input  logic        start,
    input  logic        stop,
    input  logic        load,
    input  logic [15:0] in,
    output logic [15:0] q,
    output logic        running,
    output logic        done,
    output logic        load_err,
    output logic [1:0]  state
);

    state_t      cur_state, nxt_state;
    logic [15:0] preset_r;
    logic [15:0] load_val;
    logic        dig_load, dec_en, done_nxt, err_nxt, preset_we;
    logic [3:0]  s0, s1, m0, m1;
    logic        z0, z1, z2, z3;
    logic        q_zero;

    assign q       = {m1, m0, s1, s0};
    assign q_zero  = z0 & z1 & z2 & z3;
    assign state   = cur_state;
    assign running = (cur_state == RUN);

    always_ff @(posedge clk_1Hz or negedge clr_n) begin
        if (!clr_n) begin
            cur_state <= IDLE;
            preset_r  <= TIME_ZERO;
            done      <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            done      <= done_nxt;
            load_err  <= err_nxt;
            if (preset_we) preset_r <= in;
        end
    end

    always_comb begin
        nxt_state = cur_state;
        load_val  = in;
        dig_load  = 1'b0;
        dec_en    = 1'b0;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        preset_we = 1'b0;
        if (load) begin
            if ((cur_state == RUN) || !preset_valid(in)) begin
                err_nxt = 1'b1;
            end else begin
                dig_load  = 1'b1;
                preset_we = 1'b1;
                nxt_state = IDLE;
            end
        end else if (stop && (cur_state == RUN)) begin
            nxt_state = PAUSE;
        end else if (start && ((cur_state == IDLE) || (cur_state == PAUSE)) && !q_zero) begin
            nxt_state = RUN;
        end else if (cur_state == RUN) begin
            if (q == TIME_ONE) begin
                dig_load = 1'b1;
                done_nxt = 1'b1;
`ifdef TIMER_CTRL_AUTO_RELOAD_EN
                if (preset_r != TIME_ZERO) begin
                    load_val = preset_r;
                end else begin
                    load_val  = TIME_ZERO;
                    nxt_state = DONE;
                end
`else
                load_val  = TIME_ZERO;
                nxt_state = DONE;
`endif
            end else begin
                dec_en = 1'b1;
            end
        end
    end

    // Ripple borrow: a digit steps only when every lower digit is wrapping from zero.
    bcd_down_digit #(.MAX(DIGIT_MAX_9)) u_s0 (
        .clk_1Hz(clk_1Hz), .clr_n(clr_n), .dec_en(dec_en), .load(dig_load),
        .load_val(load_val[3:0]), .digit(s0), .borrow_out(z0));
    bcd_down_digit #(.MAX(DIGIT_MAX_5)) u_s1 (
        .clk_1Hz(clk_1Hz), .clr_n(clr_n), .dec_en(dec_en & z0), .load(dig_load),
        .load_val(load_val[7:4]), .digit(s1), .borrow_out(z1));
    bcd_down_digit #(.MAX(DIGIT_MAX_9)) u_m0 (
        .clk_1Hz(clk_1Hz), .clr_n(clr_n), .dec_en(dec_en & z0 & z1), .load(dig_load),
        .load_val(load_val[11:8]), .digit(m0), .borrow_out(z2));
    bcd_down_digit #(.MAX(DIGIT_MAX_9)) u_m1 (
        .clk_1Hz(clk_1Hz), .clr_n(clr_n), .dec_en(dec_en & z0 & z1 & z2), .load(dig_load),
        .load_val(load_val[15:12]), .digit(m1), .borrow_out(z3));

endmodule

// File: tb/tb_timer_ctrl.sv
// Scoreboard bench for timer_ctrl: directed stimulus pushes expectations, a monitor pops and compares.
`timescale 1ns/1ps
module tb_timer_ctrl;

    localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSE = 2'd2, S_DONE = 2'd3;

    typedef struct {
        string       tag;
        logic [15:0] q;
        logic [1:0]  st;
        logic        d;
        logic        e;
    } exp_t;

    logic        clk_1Hz = 1'b0;
    logic        clr_n   = 1'b0;
    logic        start   = 1'b0;
    logic        stop    = 1'b0;
    logic        load    = 1'b0;
    logic [15:0] din     = 16'h0;
    logic [15:0] q;
    logic        running, done, load_err;
    logic [1:0]  state;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    event async_ev;

    timer_ctrl dut (
        .clk_1Hz(clk_1Hz), .clr_n(clr_n), .start(start), .stop(stop), .load(load),
        .in(din), .q(q), .running(running), .done(done), .load_err(load_err), .state(state)
    );

    always #5 clk_1Hz = ~clk_1Hz;

    function automatic logic [15:0] to_bcd(input int t);
        logic [3:0] a, b, c, d;
        a = 4'((t / 60) / 10);
        b = 4'((t / 60) % 10);
        c = 4'((t % 60) / 10);
        d = 4'((t % 60) % 10);
        return {a, b, c, d};
    endfunction

    task automatic expect_st(input string tag, input logic [15:0] eq, input logic [1:0] es,
                             input logic ed, input logic ee);
        exp_t x;
        x.tag = tag; x.q = eq; x.st = es; x.d = ed; x.e = ee;
        sb.push_back(x);
    endtask

    // Drive one edge worth of inputs and queue the state expected right after that edge.
    task automatic cyc(input string tag, input logic st, input logic sp, input logic ld,
                       input logic [15:0] v, input logic [15:0] eq, input logic [1:0] es,
                       input logic ed, input logic ee);
        @(negedge clk_1Hz);
        start = st; stop = sp; load = ld; din = v;
        expect_st(tag, eq, es, ed, ee);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk_1Hz or async_ev);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                checks++;
                if (q !== x.q || state !== x.st || running !== (x.st == S_RUN) ||
                    done !== x.d || load_err !== x.e) begin
                    errors++;
                    $display("FAIL %s: got q=%h state=%0d running=%b done=%b load_err=%b, want q=%h state=%0d running=%b done=%b load_err=%b",
                             x.tag, q, state, running, done, load_err,
                             x.q, x.st, (x.st == S_RUN), x.d, x.e);
                end
            end
        end
    end

    initial begin : stimulus
        #2;
        expect_st("reset", 16'h0000, S_IDLE, 1'b0, 1'b0);
        ->async_ev;
        @(negedge clk_1Hz);
        @(negedge clk_1Hz);
        clr_n = 1'b1;

        cyc("start_at_zero", 1, 0, 0, 16'h0,    16'h0000, S_IDLE, 0, 0);
        cyc("load_bad_m0",   0, 0, 1, 16'h0A00, 16'h0000, S_IDLE, 0, 1);
        cyc("err_clears",    0, 0, 0, 16'h0,    16'h0000, S_IDLE, 0, 0);
`ifdef TIMER_CTRL_AUTO_RELOAD_EN
        cyc("load_0003",     0, 0, 1, 16'h0003, 16'h0003, S_IDLE, 0, 0);
        cyc("start_0003",    1, 0, 0, 16'h0,    16'h0003, S_RUN,  0, 0);
        for (int r = 0; r < 2; r++) begin
            cyc("ar_0002",   0, 0, 0, 16'h0,    16'h0002, S_RUN,  0, 0);
            cyc("ar_0001",   0, 0, 0, 16'h0,    16'h0001, S_RUN,  0, 0);
            cyc("ar_wrap",   0, 0, 0, 16'h0,    16'h0003, S_RUN,  1, 0);
        end
        cyc("ar_stop",       0, 1, 0, 16'h0,    16'h0003, S_PAUSE, 0, 0);
`else
        cyc("load_0012",     0, 0, 1, 16'h0012, 16'h0012, S_IDLE, 0, 0);
        cyc("stop_in_idle",  0, 1, 0, 16'h0,    16'h0012, S_IDLE, 0, 0);
        cyc("start_0012",    1, 0, 0, 16'h0,    16'h0012, S_RUN,  0, 0);
        for (int t = 11; t >= 1; t--)
            cyc("count_0012", 0, 0, 0, 16'h0,   to_bcd(t), S_RUN, 0, 0);
        cyc("reach_zero",    0, 0, 0, 16'h0,    16'h0000, S_DONE, 1, 0);
        cyc("done_once",     0, 0, 0, 16'h0,    16'h0000, S_DONE, 0, 0);
        cyc("start_in_done", 1, 0, 0, 16'h0,    16'h0000, S_DONE, 0, 0);
`endif
        cyc("load_1000",     0, 0, 1, 16'h1000, 16'h1000, S_IDLE, 0, 0);
        cyc("start_1000",    1, 0, 0, 16'h0,    16'h1000, S_RUN,  0, 0);
        cyc("tick_0959",     0, 0, 0, 16'h0,    16'h0959, S_RUN,  0, 0);
        for (int k = 1; k <= 60; k++)
            cyc("count_1000", 0, 0, 0, 16'h0,   to_bcd(599 - k), S_RUN, 0, 0);
        cyc("stop_0859",     0, 1, 0, 16'h0,    16'h0859, S_PAUSE, 0, 0);
        cyc("stop_in_pause", 0, 1, 0, 16'h0,    16'h0859, S_PAUSE, 0, 0);
        cyc("load_bad_s1",   0, 0, 1, 16'h0070, 16'h0859, S_PAUSE, 0, 1);
        cyc("resume_0859",   1, 0, 0, 16'h0,    16'h0859, S_RUN,  0, 0);
        cyc("tick_0858",     0, 0, 0, 16'h0,    16'h0858, S_RUN,  0, 0);
        cyc("load_in_run",   0, 0, 1, 16'h0012, 16'h0858, S_RUN,  0, 1);
        cyc("tick_0857",     0, 0, 0, 16'h0,    16'h0857, S_RUN,  0, 0);
        cyc("load_over_stop",0, 1, 1, 16'h0100, 16'h0857, S_RUN,  0, 1);
        cyc("tick_0856",     0, 0, 0, 16'h0,    16'h0856, S_RUN,  0, 0);
        cyc("stop_0856",     0, 1, 0, 16'h0,    16'h0856, S_PAUSE, 0, 0);
        cyc("load_0530",     0, 0, 1, 16'h0530, 16'h0530, S_IDLE, 0, 0);
        cyc("start_0530",    1, 0, 0, 16'h0,    16'h0530, S_RUN,  0, 0);
        cyc("stop_and_start",1, 1, 0, 16'h0,    16'h0530, S_PAUSE, 0, 0);
        cyc("restart_0530",  1, 0, 0, 16'h0,    16'h0530, S_RUN,  0, 0);
        cyc("tick_0529",     0, 0, 0, 16'h0,    16'h0529, S_RUN,  0, 0);
        cyc("tick_0528",     0, 0, 0, 16'h0,    16'h0528, S_RUN,  0, 0);

        @(negedge clk_1Hz);
        start = 0; stop = 0; load = 0; din = 16'h0;
        #2;
        clr_n = 1'b0;
        expect_st("async_clear", 16'h0000, S_IDLE, 1'b0, 1'b0);
        ->async_ev;
        cyc("held_in_clear", 0, 0, 0, 16'h0,    16'h0000, S_IDLE, 0, 0);
        @(negedge clk_1Hz);
        clr_n = 1'b1;
        expect_st("after_release", 16'h0000, S_IDLE, 1'b0, 1'b0);

        cyc("load_9959",     0, 0, 1, 16'h9959, 16'h9959, S_IDLE, 0, 0);
        cyc("load_bad_9960", 0, 0, 1, 16'h9960, 16'h9959, S_IDLE, 0, 1);
        cyc("start_9959",    1, 0, 0, 16'h0,    16'h9959, S_RUN,  0, 0);
        cyc("tick_9958",     0, 0, 0, 16'h0,    16'h9958, S_RUN,  0, 0);
        @(negedge clk_1Hz);
        start = 0; stop = 0; load = 0;

        for (int w = 0; w < 10 && sb.size() > 0; w++) @(negedge clk_1Hz);
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d unchecked expectations, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/timer_ctrl.md
TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 SHALL have port clk_1Hz, input, 1 bit: single clock, rising edge; each edge is one count tick.
REQ-002 SHALL have port clr_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port start, input, 1 bit: level, sampled each edge; requests RUN.
REQ-004 SHALL have port stop, input, 1 bit: level, sampled each edge; requests PAUSE.
REQ-005 SHALL have port load, input, 1 bit: level, sampled each edge; requests preset load.
REQ-006 SHALL have port in, input, 16 bits: preset BCD digits {m1,m0,s1,s0}, 4 bits each.
REQ-007 SHALL have port q, output, 16 bits: current BCD time {m1,m0,s1,s0}, registered.
REQ-008 SHALL have port running, output, 1 bit: high while in RUN.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse on reaching 00:00.
REQ-010 SHALL have port load_err, output, 1 bit: one-cycle pulse on a rejected load.
REQ-011 SHALL have port state, output, 2 bits: current FSM state code.

Function
REQ-012 SHALL implement the states IDLE=0, RUN=1, PAUSE=2, DONE=3.
REQ-013 SHALL resolve same-edge requests with priority load > stop > start.
REQ-014 SHALL, on load in IDLE, PAUSE or DONE with a valid preset, register the preset into q and the preset register next edge and enter IDLE.
REQ-015 SHALL treat a preset as valid only if every digit is at most 9 and s1 is at most 5.
REQ-016 SHALL, for an invalid preset or a load during RUN, leave q and state unchanged and pulse load_err for one cycle.
REQ-017 SHALL, on start in IDLE or PAUSE with q not equal to 0000, enter RUN next edge without decrementing on that edge.
REQ-018 SHALL ignore start when q equals 0000.
REQ-019 SHALL, in RUN with no stop or load, decrement q by one second per edge as a BCD countdown.
REQ-020 SHALL borrow as follows: s0 wraps 0->9 and borrows from s1; s1 wraps 0->5 and borrows from m0; m0 wraps 0->9 and borrows from m1.
REQ-021 SHALL, in RUN when q equals 0001, load q=0000, enter DONE and assert done for exactly the following cycle.
REQ-022 SHALL, on stop in RUN, enter PAUSE next edge with q frozen; q is not decremented on that edge.
REQ-023 SHALL ignore stop outside RUN.
REQ-024 SHALL keep DONE with q=0000 until a valid load.
REQ-025 SHALL derive running combinationally from state equal to RUN.
REQ-026 SHALL hold q at or below 99:59 at all times and never produce non-BCD digits.

Reset
REQ-027 SHALL, while clr_n is low, immediately force state=IDLE, q=0000, preset register=0000, running=0, done=0 and load_err=0, regardless of clock.
REQ-028 SHALL, on deassertion of clr_n mid-RUN, resume in IDLE with no done pulse; the first decision is made on the next rising edge.

Configuration
REQ-029 SHALL support the macro TIMER_CTRL_AUTO_RELOAD_EN.
REQ-030 SHALL, with TIMER_CTRL_AUTO_RELOAD_EN defined, reload q from the preset register on the 0001->done edge instead of loading 0000, remain in RUN and still pulse done; a zero preset falls back to DONE.
REQ-031 SHALL, without TIMER_CTRL_AUTO_RELOAD_EN, behave as in REQ-021 and omit the reload path.

Structure
REQ-032 SHALL place in package timer_ctrl_pkg: the state encoding constants, BCD digit width (4), digit maxima (9, 5) and the zero-time constant.
REQ-033 SHALL instantiate a sub-module bcd_down_digit four times: 4-bit digit, parameter MAX, inputs dec_en and load, outputs digit and borrow_out; timer_ctrl holds the FSM and chains the borrows.

Verification
REQ-034 SHALL cover: load in=0012, start, 12 edges -> q runs 0011, 0010, 0009 ... 0000; done high for one cycle; state=DONE.
REQ-035 SHALL cover: load 1000, start, 1 tick -> q=0959; then 60 more ticks -> q=0859.
REQ-036 SHALL cover: load in=0070 (s1=7) -> load_err pulse; q and state unchanged; load during RUN -> load_err, counting continues.
REQ-037 SHALL cover: RUN at 0530, then stop and start on the same edge -> PAUSE with q=0530; start -> RUN resumes at 0529 one edge later.
REQ-038 SHALL cover: clr_n low between edges during RUN -> q=0000 and state=IDLE immediately; no done pulse.
REQ-039 SHALL cover, with TIMER_CTRL_AUTO_RELOAD_EN defined: preset 0003 -> q runs 0002, 0001, 0003; done pulses on each wrap; running stays high.
